// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID/EX pipeline slice: default datapath width,
// ALU operation and result-source encodings, and the decoded control bundle
// (ctrl_t) that travels from decode into execute.
// No ports (package).
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int XLEN_DEFAULT = 32;

    // ALU operation encodings carried in ctrl_t.alu_ctrl
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;
    localparam logic [3:0] ALU_LUI  = 4'd10;

    // Write-back result source encodings carried in ctrl_t.result_src
    localparam logic [1:0] RES_ALU = 2'd0;
    localparam logic [1:0] RES_MEM = 2'd1;
    localparam logic [1:0] RES_PC4 = 2'd2;
    localparam logic [1:0] RES_IMM = 2'd3;

    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;     // 1: operand B is the immediate
        logic [3:0] alu_ctrl;
        logic [1:0] result_src;
    } ctrl_t;

endpackage

// File: rtl/fwd_unit.sv
// ---------------------------------------------------------------------------
// fwd_unit
// Operand bypass select for one source register in EX. The EX/MEM result is
// newer than the MEM/WB result, so it wins when both match. Register x0 is
// never bypassed; its stored (zero) value is passed through.
// Ports:
//   ex_rs         in  5     source index held in the ID/EX register
//   ex_val        in  XLEN  register-file value held in the ID/EX register
//   mem_rd        in  5     EX/MEM destination index
//   mem_reg_write in  1     EX/MEM writes a register
//   mem_result    in  XLEN  EX/MEM result
//   wb_rd         in  5     MEM/WB destination index
//   wb_reg_write  in  1     MEM/WB writes a register
//   wb_result     in  XLEN  MEM/WB result
//   fwd_val       out XLEN  selected operand value
// ---------------------------------------------------------------------------
import pipe_pkg::*;

module fwd_unit #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [4:0]      ex_rs,
    input  logic [XLEN-1:0] ex_val,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic [XLEN-1:0] fwd_val
);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs);
    assign wb_hit  = wb_reg_write  && (wb_rd  != 5'd0) && (wb_rd  == ex_rs);

    always_comb begin
        fwd_val = ex_val;
        if (mem_hit) begin
            fwd_val = mem_result;
        end else if (wb_hit) begin
            fwd_val = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use hazard detection and EX operand
// forwarding. A load in EX whose destination is read by the instruction in
// ID stalls IF/ID and inserts a bubble; a taken branch/jump (flush) also
// inserts a bubble and overrides everything else.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_valid, id_pc, id_rd1, id_rd2  decode instruction, PC, regfile data
//   id_rs1, id_rs2, id_rd, id_imm    register indices, immediate
//   id_ctrl                          decoded controls (ctrl_t)
//   flush                            kill the instruction entering EX
//   mem_rd/mem_reg_write/mem_result  EX/MEM forwarding source
//   wb_rd/wb_reg_write/wb_result     MEM/WB forwarding source
//   stall_if_id                      out: hold PC and IF/ID (load-use)
//   ex_valid, ex_pc, ex_imm, ex_rd,  out: registered decode fields
//   ex_ctrl
//   ex_src_a, ex_src_b               out: forwarded ALU operands
//   ex_store_data                    out: forwarded rs2 for stores
// ---------------------------------------------------------------------------
import pipe_pkg::*;

module id_ex_stage #(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rd1,
    input  logic [XLEN-1:0] id_rd2,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_imm,
    input  ctrl_t           id_ctrl,
    input  logic            flush,
    input  logic [4:0]      mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_result,
    input  logic [4:0]      wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_result,
    output logic            stall_if_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output ctrl_t           ex_ctrl,
    output logic [XLEN-1:0] ex_src_a,
    output logic [XLEN-1:0] ex_src_b,
    output logic [XLEN-1:0] ex_store_data
);

    logic [4:0]      rs1_p0;
    logic [4:0]      rs2_p0;
    logic [XLEN-1:0] rd1_p0;
    logic [XLEN-1:0] rd2_p0;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            bubble;

    // Load in EX feeding the instruction in ID: its data is not ready until
    // after MEM, so forwarding cannot cover it.
    assign stall_if_id = ex_valid && ex_ctrl.mem_read && (ex_rd != 5'd0) &&
                         id_valid && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    assign bubble = flush || stall_if_id;

    // ---- ID -> EX stage boundary ----
    // A bubble clears only validity and the side-effect enables; data fields
    // keep their previous contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_pc    <= '0;
            ex_imm   <= '0;
            ex_rd    <= '0;
            rs1_p0   <= '0;
            rs2_p0   <= '0;
            rd1_p0   <= '0;
            rd2_p0   <= '0;
        end else if (bubble) begin
            ex_valid          <= 1'b0;
            ex_ctrl.reg_write <= 1'b0;
            ex_ctrl.mem_read  <= 1'b0;
            ex_ctrl.mem_write <= 1'b0;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_ctrl;
            ex_pc    <= id_pc;
            ex_imm   <= id_imm;
            ex_rd    <= id_rd;
            rs1_p0   <= id_rs1;
            rs2_p0   <= id_rs2;
            rd1_p0   <= id_rd1;
            rd2_p0   <= id_rd2;
        end
    end

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs1 (
        .ex_rs         (rs1_p0),
        .ex_val        (rd1_p0),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_val       (fwd_rs1)
    );

    fwd_unit #(.XLEN(XLEN)) u_fwd_rs2 (
        .ex_rs         (rs2_p0),
        .ex_val        (rd2_p0),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .fwd_val       (fwd_rs2)
    );

    assign ex_src_a      = fwd_rs1;
    assign ex_store_data = fwd_rs2;
    assign ex_src_b      = ex_ctrl.alu_src ? ex_imm : fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
import pipe_pkg::*;

module tb_id_ex_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [XLEN-1:0] id_rd1;
    logic [XLEN-1:0] id_rd2;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic [XLEN-1:0] id_imm;
    ctrl_t           id_ctrl;
    logic            flush;
    logic [4:0]      mem_rd;
    logic            mem_reg_write;
    logic [XLEN-1:0] mem_result;
    logic [4:0]      wb_rd;
    logic            wb_reg_write;
    logic [XLEN-1:0] wb_result;
    logic            stall_if_id;
    logic            ex_valid;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    ctrl_t           ex_ctrl;
    logic [XLEN-1:0] ex_src_a;
    logic [XLEN-1:0] ex_src_b;
    logic [XLEN-1:0] ex_store_data;

    int passed = 0;
    int total  = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_rd1        (id_rd1),
        .id_rd2        (id_rd2),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_imm        (id_imm),
        .id_ctrl       (id_ctrl),
        .flush         (flush),
        .mem_rd        (mem_rd),
        .mem_reg_write (mem_reg_write),
        .mem_result    (mem_result),
        .wb_rd         (wb_rd),
        .wb_reg_write  (wb_reg_write),
        .wb_result     (wb_result),
        .stall_if_id   (stall_if_id),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_imm        (ex_imm),
        .ex_rd         (ex_rd),
        .ex_ctrl       (ex_ctrl),
        .ex_src_a      (ex_src_a),
        .ex_src_b      (ex_src_b),
        .ex_store_data (ex_store_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are
    // sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] rd1,
                          input logic [31:0] rd2, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [31:0] imm, input ctrl_t c);
        id_valid = v;
        id_pc    = pc;
        id_rd1   = rd1;
        id_rd2   = rd2;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_imm   = imm;
        id_ctrl  = c;
    endtask

    ctrl_t c_alu;
    ctrl_t c_alui;
    ctrl_t c_lw;
    ctrl_t c_sw;

    initial begin
        c_alu  = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, alu_src:1'b0, alu_ctrl:ALU_ADD, result_src:RES_ALU};
        c_alui = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b0, alu_src:1'b1, alu_ctrl:ALU_ADD, result_src:RES_ALU};
        c_lw   = '{reg_write:1'b1, mem_read:1'b1, mem_write:1'b0, alu_src:1'b1, alu_ctrl:ALU_ADD, result_src:RES_MEM};
        c_sw   = '{reg_write:1'b0, mem_read:1'b0, mem_write:1'b1, alu_src:1'b1, alu_ctrl:ALU_ADD, result_src:RES_ALU};

        rst_n = 1'b0;
        flush = 1'b0;
        set_id(1'b1, 32'h0000_0500, 32'h1234, 32'h5678, 5'd1, 5'd2, 5'd3, 32'h99, c_lw);
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h55;
        wb_rd  = 5'd0; wb_reg_write  = 1'b1; wb_result  = 32'h66;

        // Reset state, including across a clock edge with decode active
        tick();
        check("rst_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_ctrl", {22'd0, ex_ctrl}, 32'd0);
        check("rst_stall", {31'd0, stall_if_id}, 32'd0);
        check("rst_src_a", ex_src_a, 32'd0);
        check("rst_store", ex_store_data, 32'd0);
        check("rst_pc", ex_pc, 32'd0);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;
        #2 rst_n = 1'b1;

        // Plain capture: add with rd1=5, rd2=7
        set_id(1'b1, 32'h0000_0100, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'h40, c_alu);
        tick();
        check("cap_valid", {31'd0, ex_valid}, 32'd1);
        check("cap_src_a", ex_src_a, 32'd5);
        check("cap_src_b", ex_src_b, 32'd7);
        check("cap_store", ex_store_data, 32'd7);
        check("cap_pc", ex_pc, 32'h100);
        check("cap_rd", {27'd0, ex_rd}, 32'd3);
        check("cap_ctrl", {22'd0, ex_ctrl}, {22'd0, c_alu});

        // Immediate operand selects ex_imm for B, store data stays rs2
        set_id(1'b1, 32'h0000_0104, 32'd5, 32'd7, 5'd1, 5'd2, 5'd3, 32'h40, c_alui);
        tick();
        check("imm_src_b", ex_src_b, 32'h40);
        check("imm_store", ex_store_data, 32'd7);

        // EX/MEM vs MEM/WB priority on rs1
        set_id(1'b1, 32'h0000_0108, 32'd9, 32'd11, 5'd3, 5'd6, 5'd8, 32'h0, c_alu);
        tick();
        mem_rd = 5'd3; mem_reg_write = 1'b1; mem_result = 32'hAAAA_AAAA;
        wb_rd  = 5'd3; wb_reg_write  = 1'b1; wb_result  = 32'd1;
        #1;
        check("fwd_mem_a", ex_src_a, 32'hAAAA_AAAA);
        check("fwd_mem_b_nomatch", ex_src_b, 32'd11);
        mem_reg_write = 1'b0;
        #1;
        check("fwd_wb_a", ex_src_a, 32'd1);
        wb_reg_write = 1'b0;
        #1;
        check("fwd_none_a", ex_src_a, 32'd9);
        // MEM/WB forward on rs2 reaches B and store data
        wb_rd = 5'd6; wb_reg_write = 1'b1; wb_result = 32'h77;
        #1;
        check("fwd_wb_b", ex_src_b, 32'h77);
        check("fwd_wb_store", ex_store_data, 32'h77);
        wb_reg_write = 1'b0;

        // x0 guard: rs2 = x0 with both sources claiming index 0
        set_id(1'b1, 32'h0000_010C, 32'd0, 32'd0, 5'd0, 5'd0, 5'd9, 32'h0, c_sw);
        tick();
        mem_rd = 5'd0; mem_reg_write = 1'b1; mem_result = 32'h55;
        wb_rd  = 5'd0; wb_reg_write  = 1'b1; wb_result  = 32'h66;
        #1;
        check("x0_store", ex_store_data, 32'd0);
        check("x0_src_a", ex_src_a, 32'd0);
        mem_reg_write = 1'b0; wb_reg_write = 1'b0;

        // Load-use: lw x4 in EX, consumer reads x4 via rs2
        set_id(1'b1, 32'h0000_0110, 32'd0, 32'd0, 5'd1, 5'd0, 5'd4, 32'h8, c_lw);
        tick();
        check("lw_valid", {31'd0, ex_valid}, 32'd1);
        set_id(1'b1, 32'h0000_0114, 32'd1, 32'd2, 5'd0, 5'd4, 5'd5, 32'h0, c_sw);
        #1;
        check("lu_stall", {31'd0, stall_if_id}, 32'd1);
        id_rs2 = 5'd5;
        #1;
        check("lu_nomatch", {31'd0, stall_if_id}, 32'd0);
        id_rs2 = 5'd4; id_valid = 1'b0;
        #1;
        check("lu_idinvalid", {31'd0, stall_if_id}, 32'd0);
        id_valid = 1'b1;
        id_ctrl = '{reg_write:1'b1, mem_read:1'b0, mem_write:1'b1, alu_src:1'b0, alu_ctrl:ALU_SUB, result_src:RES_ALU};
        tick();
        check("bub_valid", {31'd0, ex_valid}, 32'd0);
        check("bub_regwr", {31'd0, ex_ctrl.reg_write}, 32'd0);
        check("bub_memrd", {31'd0, ex_ctrl.mem_read}, 32'd0);
        check("bub_memwr", {31'd0, ex_ctrl.mem_write}, 32'd0);
        check("bub_pc_held", ex_pc, 32'h110);
        check("bub_stall_clear", {31'd0, stall_if_id}, 32'd0);

        // Stalled instruction now enters EX normally
        tick();
        check("resume_valid", {31'd0, ex_valid}, 32'd1);
        check("resume_pc", ex_pc, 32'h114);

        // Flush with load-use active: bubble, store enable cleared
        set_id(1'b1, 32'h0000_0118, 32'd0, 32'd0, 5'd1, 5'd0, 5'd7, 32'h0, c_lw);
        tick();
        set_id(1'b1, 32'h0000_011C, 32'd0, 32'd0, 5'd7, 5'd2, 5'd0, 32'h0, c_sw);
        flush = 1'b1;
        #1;
        check("fl_stall", {31'd0, stall_if_id}, 32'd1);
        tick();
        check("fl_valid", {31'd0, ex_valid}, 32'd0);
        check("fl_memwr", {31'd0, ex_ctrl.mem_write}, 32'd0);

        // Flush alone on a hazard-free store
        set_id(1'b1, 32'h0000_0120, 32'd0, 32'd3, 5'd1, 5'd2, 5'd0, 32'h0, c_sw);
        tick();
        check("flonly_valid", {31'd0, ex_valid}, 32'd0);
        check("flonly_memwr", {31'd0, ex_ctrl.mem_write}, 32'd0);
        check("flonly_pc_held", ex_pc, 32'h118);
        flush = 1'b0;
        tick();
        check("after_flush_valid", {31'd0, ex_valid}, 32'd1);
        check("after_flush_memwr", {31'd0, ex_ctrl.mem_write}, 32'd1);

        // Asynchronous reset between edges
        set_id(1'b1, 32'h0000_0200, 32'd21, 32'd22, 5'd1, 5'd2, 5'd10, 32'h4, c_alu);
        tick();
        check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, ex_valid}, 32'd0);
        check("arst_pc", ex_pc, 32'd0);
        check("arst_src_a", ex_src_a, 32'd0);
        tick();
        check("arst_hold_valid", {31'd0, ex_valid}, 32'd0);
        #2 rst_n = 1'b1;
        #1;
        check("arst_release_valid", {31'd0, ex_valid}, 32'd0);
        tick();
        check("arst_first_valid", {31'd0, ex_valid}, 32'd1);
        check("arst_first_src_a", ex_src_a, 32'd21);
        check("arst_first_pc", ex_pc, 32'h200);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width.
REQ-002 clk  in  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 id_valid  in  1  decode stage holds a real instruction.
REQ-005 id_pc  in  XLEN  PC of decoded instruction.
REQ-006 id_rd1, id_rd2  in  XLEN each  register-file read data (x0 already reads 0).
REQ-007 id_rs1, id_rs2, id_rd  in  5 each  source/destination register indices.
REQ-008 id_imm  in  XLEN  sign-extended immediate.
REQ-009 id_ctrl  in  ctrl_t  decoded controls: reg_write, mem_read, mem_write, alu_src, alu_ctrl[3:0], result_src[1:0].
REQ-010 flush  in  1  branch/jump taken in EX; kill the instruction entering EX.
REQ-011 mem_rd, mem_reg_write, mem_result  in  5/1/XLEN  EX/MEM forwarding source.
REQ-012 wb_rd, wb_reg_write, wb_result  in  5/1/XLEN  MEM/WB forwarding source.
REQ-013 stall_if_id  out  1  hold PC and IF/ID register (load-use hazard).
REQ-014 ex_valid, ex_pc, ex_imm, ex_rd, ex_ctrl  out  registered copies of decode fields.
REQ-015 ex_src_a, ex_src_b  out  XLEN each  forwarded ALU operands (src_b after alu_src mux).
REQ-016 ex_store_data  out  XLEN  forwarded rs2 value for stores.

Function
REQ-017 Stage register: on rising clk, capture all id_* fields into ex_* state; latency one cycle.
REQ-018 Load-use hazard: stall_if_id = 1 when ex_valid & ex_ctrl.mem_read & ex_rd != 0 & id_valid & (ex_rd == id_rs1 | ex_rd == id_rs2); combinational, same cycle.
REQ-019 When stall_if_id = 1, next cycle captures a bubble: ex_valid = 0 and all ex_ctrl write/memory enables = 0.
REQ-020 When flush = 1, next cycle captures a bubble regardless of stall; flush has priority over stall and capture.
REQ-021 Bubble: ex_valid, reg_write, mem_read, mem_write = 0; data fields don't-care but held at previous values.
REQ-022 Forward select per operand (rs1, rs2 stored in ex state): EX/MEM if mem_reg_write & mem_rd != 0 & mem_rd == ex_rsN; else MEM/WB if wb_reg_write & wb_rd != 0 & wb_rd == ex_rsN; else stored ex_rdN.
REQ-023 EX/MEM has priority over MEM/WB when both match (newest value wins).
REQ-024 Register index 0 never forwarded; operand for x0 is the stored value (0).
REQ-025 ex_src_a = forwarded rs1; ex_store_data = forwarded rs2; ex_src_b = ex_imm when ex_ctrl.alu_src = 1, else forwarded rs2.
REQ-026 Forwarding is combinational from forwarding inputs to ex_src_a/ex_src_b/ex_store_data; no added latency.
REQ-027 The same-cycle WB-to-ID case is not forwarded here: regfile writes on negedge, so id_rd1/id_rd2 are already current.
REQ-028 All arithmetic widths XLEN; no truncation or extension inside this block.

Reset
REQ-029 rst_n low asynchronously forces ex_valid = 0, ex_ctrl all zero, ex_pc/ex_imm/ex_rd/stored operands/stored indices = 0.
REQ-030 During reset stall_if_id = 0; ex_src_a/ex_src_b/ex_store_data = 0 unless a forwarding input matches index 0 (never, by REQ-024).
REQ-031 Reset deassertion mid-pipeline: first rising clk after release captures decode inputs normally.

Structure
REQ-032 ctrl_t struct, alu_ctrl encodings, result_src encodings, and XLEN default live in shared package pipe_pkg.
REQ-033 One sub-module fwd_unit: select logic for a single operand, instantiated twice (rs1, rs2).
REQ-034 Hazard detection and stage register live in id_ex_stage top.

Verification
REQ-035 Plain capture: id_rd1=5, id_rd2=7, alu_src=0, no matches -> next cycle ex_src_a=5, ex_src_b=7, ex_valid=1.
REQ-036 EX/MEM forward: ex_rs1=3, mem_rd=3, mem_reg_write=1, mem_result=0xAAAA_AAAA, wb_rd=3, wb_result=1 -> ex_src_a=0xAAAA_AAAA.
REQ-037 x0 guard: ex_rs2=0, mem_rd=0, mem_reg_write=1, mem_result=0x55 -> ex_store_data=0.
REQ-038 Load-use: ex holds lw x4 (mem_read=1, ex_rd=4), id_rs2=4, id_valid=1 -> stall_if_id=1, next cycle ex_valid=0, reg_write=0.
REQ-039 Flush vs stall: flush=1 with load-use hazard active -> next cycle bubble, ex_ctrl.mem_write=0.
REQ-040 Async reset: assert rst_n=0 between clock edges with ex_valid=1 -> ex_valid=0 immediately, held until first edge after release.
